// File: rtl/io_port_controller.sv
// rtl/io_port_controller.sv - CPU I/O block: hex seven-segment output, switch handshake, buffered PS/2 keyboard input
module io_port_controller #(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_DIGITS     = 8,
    parameter int SW_WIDTH       = 18,
    parameter int KB_DEPTH       = 8,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic [1:0]              io_i,
    input  logic [DATA_WIDTH-1:0]   data_out_i,
    input  logic                    blank_leading_i,
    input  logic [SW_WIDTH-1:0]     raw_input_i,
    input  logic                    confirm_i,
    input  logic [7:0]              kb_byte_i,
    input  logic                    kb_valid_i,
    output logic [DATA_WIDTH-1:0]   data_in_o,
    output logic                    data_in_valid_o,
    output logic                    interrupt_o,
    output logic                    kb_empty_o,
    output logic                    kb_full_o,
    output logic                    kb_overflow_o,
    output logic [DATA_WIDTH-1:0]   debug_7seg_o,
    output logic [7*NUM_DIGITS-1:0] displays_o
);

    localparam int PTR_W = (KB_DEPTH > 1) ? $clog2(KB_DEPTH) : 1;
    localparam int CNT_W = $clog2(KB_DEPTH + 1);
    localparam int NIB_W = 4 * NUM_DIGITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SW_PRESS,
        S_SW_RELEASE,
        S_KB_WAIT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
    logic                  valid_q, valid_d;
    logic                  interrupt_q, interrupt_d;
    logic [DATA_WIDTH-1:0] disp_q, disp_d;
    logic                  overflow_q, overflow_d;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [7:0]            kb_mem [KB_DEPTH];

    logic kb_empty, kb_full, do_pop, kb_done, push_ok, drop;

    assign kb_empty = (count_q == '0);
    assign kb_full  = (count_q == CNT_W'(KB_DEPTH));
    // A full FIFO still accepts a byte when the same cycle frees a slot.
    assign push_ok  = kb_valid_i & (~kb_full | do_pop);
    assign drop     = kb_valid_i & kb_full & ~do_pop;

    always_comb begin
        state_d     = state_q;
        data_in_d   = data_in_q;
        valid_d     = 1'b0;
        interrupt_d = interrupt_q;
        disp_d      = disp_q;
        do_pop      = 1'b0;
        kb_done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    case (io_i)
                        2'd0: begin
                            disp_d  = data_out_i;
                            state_d = S_DONE;
                        end
                        2'd1: begin
                            interrupt_d = 1'b1;
                            state_d     = S_SW_PRESS;
                        end
                        2'd2: begin
                            if (!kb_empty) begin
                                do_pop    = 1'b1;
                                kb_done   = 1'b1;
                                data_in_d = DATA_WIDTH'(kb_mem[rd_ptr_q]);
                                valid_d   = 1'b1;
                                state_d   = S_DONE;
                            end else begin
                                interrupt_d = 1'b1;
                                state_d     = S_KB_WAIT;
                            end
                        end
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_SW_PRESS: begin
                if (confirm_i) begin
                    data_in_d = DATA_WIDTH'($signed(raw_input_i));
                    state_d   = S_SW_RELEASE;
                end
            end
            S_SW_RELEASE: begin
                if (!confirm_i) begin
                    interrupt_d = 1'b0;
                    valid_d     = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_KB_WAIT: begin
                if (!kb_empty) begin
                    do_pop      = 1'b1;
                    kb_done     = 1'b1;
                    data_in_d   = DATA_WIDTH'(kb_mem[rd_ptr_q]);
                    valid_d     = 1'b1;
                    interrupt_d = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (!enable_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (kb_done) overflow_d = 1'b0;
        if (drop)    overflow_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            data_in_q   <= '0;
            valid_q     <= 1'b0;
            interrupt_q <= 1'b0;
            disp_q      <= '0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            data_in_q   <= data_in_d;
            valid_q     <= valid_d;
            interrupt_q <= interrupt_d;
            disp_q      <= disp_d;
            overflow_q  <= overflow_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) kb_mem[wr_ptr_q] <= kb_byte_i;
    end

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'h3F;
            4'h1: hex_glyph = 7'h06;
            4'h2: hex_glyph = 7'h5B;
            4'h3: hex_glyph = 7'h4F;
            4'h4: hex_glyph = 7'h66;
            4'h5: hex_glyph = 7'h6D;
            4'h6: hex_glyph = 7'h7D;
            4'h7: hex_glyph = 7'h07;
            4'h8: hex_glyph = 7'h7F;
            4'h9: hex_glyph = 7'h6F;
            4'hA: hex_glyph = 7'h77;
            4'hB: hex_glyph = 7'h7C;
            4'hC: hex_glyph = 7'h39;
            4'hD: hex_glyph = 7'h5E;
            4'hE: hex_glyph = 7'h79;
            default: hex_glyph = 7'h71;
        endcase
    endfunction

    // Nibbles past the register width read as zero.
    logic [NIB_W-1:0] nibs;
    generate
        if (DATA_WIDTH >= NIB_W) begin : g_nib_trunc
            assign nibs = disp_q[NIB_W-1:0];
        end else begin : g_nib_ext
            assign nibs = {{(NIB_W-DATA_WIDTH){1'b0}}, disp_q};
        end
    endgenerate

    logic [7*NUM_DIGITS-1:0] segs;
    logic                    seen;
    logic [3:0]              nib;
    logic                    lit;
    logic [6:0]              pat;

    // Scan from the top digit so "seen" marks every digit at or below the leading nonzero nibble.
    always_comb begin
        segs = '0;
        seen = 1'b0;
        nib  = '0;
        lit  = 1'b0;
        pat  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nib  = nibs[4*k +: 4];
            seen = seen | (nib != 4'h0);
            lit  = seen | (k == 0) | ~blank_leading_i;
            pat  = lit ? hex_glyph(nib) : 7'h00;
            segs[7*k +: 7] = (SEG_ACTIVE_LOW != 0) ? ~pat : pat;
        end
    end

    assign data_in_o       = data_in_q;
    assign data_in_valid_o = valid_q;
    assign interrupt_o     = interrupt_q;
    assign kb_empty_o      = kb_empty;
    assign kb_full_o       = kb_full;
    assign kb_overflow_o   = overflow_q;
    assign debug_7seg_o    = disp_q;
    assign displays_o      = segs;

endmodule

// File: tb/tb_io_port_controller.sv
// tb/tb_io_port_controller.sv - self-checking bench for io_port_controller
module tb_io_port_controller;

    localparam int DW    = 32;
    localparam int ND    = 8;
    localparam int SWW   = 18;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           reset, enable, blank, confirm, kb_valid;
    logic [1:0]     io;
    logic [DW-1:0]  data_out;
    logic [SWW-1:0] raw;
    logic [7:0]     kb_byte;
    logic [DW-1:0]  data_in, debug;
    logic           valid, irq, kb_empty, kb_full, kb_ovf;
    logic [7*ND-1:0] displays;

    always #5 clk = ~clk;

    io_port_controller dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .io_i(io),
        .data_out_i(data_out), .blank_leading_i(blank), .raw_input_i(raw),
        .confirm_i(confirm), .kb_byte_i(kb_byte), .kb_valid_i(kb_valid),
        .data_in_o(data_in), .data_in_valid_o(valid), .interrupt_o(irq),
        .kb_empty_o(kb_empty), .kb_full_o(kb_full), .kb_overflow_o(kb_ovf),
        .debug_7seg_o(debug), .displays_o(displays)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] kbq[$];
    logic       ovf_m;

    logic [6:0] glyph_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        logic [31:0] data;
        logic        blank;
        logic [55:0] exp;
    } disp_vec_t;
    disp_vec_t dv [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [55:0] model_disp(input logic [31:0] v, input logic bl);
        int top = 0;
        int nib;
        logic [55:0] r;
        for (int k = 0; k < 8; k++)
            if (((v >> (4 * k)) & 32'hF) != 0) top = k;
        for (int k = 0; k < 8; k++) begin
            nib = int'((v >> (4 * k)) & 32'hF);
            if (bl && k > top) r[7*k +: 7] = 7'h7F;
            else               r[7*k +: 7] = ~glyph_hi[nib];
        end
        return r;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        kbq.delete();
        ovf_m = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        kb_valid = 1'b1;
        kb_byte  = b;
        tick();
        kb_valid = 1'b0;
    endtask

    task automatic kb_read(input string name, input logic [7:0] exp);
        enable = 1'b1;
        io     = 2'd2;
        tick();
        check({name, "_data"}, data_in, {24'h0, exp});
        check({name, "_valid"}, valid, 1);
        enable = 1'b0;
        tick();
    endtask

    initial begin
        int pulses;
        bit seen;
        logic [7:0] b;
        logic [31:0] v;
        logic       bl, pw;

        dv[0] = '{32'h000000A5, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12}};
        dv[1] = '{32'h00000000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        dv[2] = '{32'h00000000, 1'b0, {8{7'h40}}};
        dv[3] = '{32'h12345678, 1'b1, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}};
        dv[4] = '{32'h0F00E000, 1'b1, {7'h7F, 7'h0E, 7'h40, 7'h40, 7'h06, 7'h40, 7'h40, 7'h40}};

        enable = 0; io = 0; data_out = 0; blank = 0; raw = 0; confirm = 0;
        kb_byte = 0; kb_valid = 0; reset = 1;
        do_reset();

        check("rst_displays", displays, {8{7'h40}});
        check("rst_data_in", data_in, 0);
        check("rst_valid", valid, 0);
        check("rst_irq", irq, 0);
        check("rst_kb_empty", kb_empty, 1);
        check("rst_kb_full", kb_full, 0);
        check("rst_kb_ovf", kb_ovf, 0);
        check("rst_debug", debug, 0);

        for (int i = 0; i < 5; i++) begin
            enable = 1; io = 0; data_out = dv[i].data; blank = dv[i].blank;
            tick();
            check($sformatf("disp_vec%0d_seg", i), displays, dv[i].exp);
            check($sformatf("disp_vec%0d_dbg", i), debug, dv[i].data);
            data_out = 32'hDEADBEEF;
            enable = 0;
            tick();
            check($sformatf("disp_vec%0d_hold", i), debug, dv[i].data);
        end

        // Switch handshake with a held Enable afterwards.
        enable = 1; io = 1; raw = 18'h3FFFF; confirm = 0;
        tick();
        check("sw_irq_on", irq, 1);
        check("sw_no_valid_wait", valid, 0);
        repeat (2) tick();
        check("sw_irq_held", irq, 1);
        confirm = 1;
        tick();
        raw = 18'h00000;
        check("sw_press_data", data_in, 32'hFFFFFFFF);
        tick();
        tick();
        check("sw_raw_not_recaptured", data_in, 32'hFFFFFFFF);
        check("sw_irq_during_press", irq, 1);
        check("sw_no_valid_press", valid, 0);
        confirm = 0;
        tick();
        check("sw_release_valid", valid, 1);
        check("sw_release_irq", irq, 0);
        check("sw_release_data", data_in, 32'hFFFFFFFF);
        pulses = 0;
        repeat (10) begin
            tick();
            if (valid) pulses++;
        end
        check("sw_no_retrigger", pulses, 0);
        check("sw_irq_stays_low", irq, 0);
        enable = 0;
        tick();

        // Two buffered bytes.
        push_byte(8'h1C);
        push_byte(8'h32);
        check("kb_not_empty", kb_empty, 0);
        kb_read("kb_rd0", 8'h1C);
        kb_read("kb_rd1", 8'h32);
        check("kb_empty_after", kb_empty, 1);

        // Read from an empty FIFO stalls until a byte arrives.
        enable = 1; io = 2;
        tick();
        check("kbw_irq_on", irq, 1);
        check("kbw_no_valid", valid, 0);
        repeat (3) tick();
        check("kbw_irq_held", irq, 1);
        push_byte(8'h5A);
        seen = 0;
        for (int i = 0; i < 2 && !seen; i++) begin
            tick();
            if (valid) seen = 1;
        end
        check("kbw_valid_seen", seen, 1);
        check("kbw_data", data_in, 32'h5A);
        check("kbw_irq_off", irq, 0);
        enable = 0;
        tick();

        // Fill, overflow, then simultaneous push and pop while full.
        for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + 8'(i));
        check("fill_full", kb_full, 1);
        check("fill_no_ovf", kb_ovf, 0);
        push_byte(8'hFF);
        check("ovf_set", kb_ovf, 1);
        check("ovf_still_full", kb_full, 1);
        enable = 1; io = 2; kb_valid = 1; kb_byte = 8'hEE;
        tick();
        kb_valid = 0;
        check("pp_data", data_in, 32'h10);
        check("pp_valid", valid, 1);
        check("pp_full", kb_full, 1);
        check("pp_ovf_cleared", kb_ovf, 0);
        enable = 0;
        tick();
        for (int i = 0; i < DEPTH; i++)
            kb_read($sformatf("drain%0d", i), (i < DEPTH - 1) ? 8'h11 + 8'(i) : 8'hEE);
        check("drain_empty", kb_empty, 1);

        // Reset in the middle of the switch handshake.
        blank = 0;
        enable = 1; io = 1;
        tick();
        check("midrst_irq_before", irq, 1);
        reset = 1;
        tick();
        check("midrst_irq", irq, 0);
        check("midrst_displays", displays, {8{7'h40}});
        reset = 0; enable = 0;
        tick();
        enable = 1; io = 0; data_out = 32'h7;
        tick();
        check("midrst_idle_write", debug, 32'h7);
        check("midrst_irq_low", irq, 0);
        enable = 0;
        tick();

        // Randomised traffic against a transaction-level model.
        do_reset();
        for (int it = 0; it < 200; it++) begin
            int act;
            act = $urandom_range(0, 4);
            if (act <= 1) begin
                b = 8'($urandom);
                push_byte(b);
                if (kbq.size() == DEPTH) ovf_m = 1;
                else kbq.push_back(b);
            end else if (act == 2 || act == 3) begin
                if (kbq.size() > 0) begin
                    pw = 1'($urandom);
                    b = 8'($urandom);
                    enable = 1; io = 2; kb_valid = pw; kb_byte = b;
                    tick();
                    kb_valid = 0;
                    check("rnd_rd_data", data_in, {24'h0, kbq.pop_front()});
                    check("rnd_rd_valid", valid, 1);
                    ovf_m = 0;
                    if (pw) kbq.push_back(b);
                    enable = 0;
                    tick();
                end
            end else begin
                v = $urandom >> $urandom_range(0, 31);
                bl = 1'($urandom);
                enable = 1; io = 0; data_out = v; blank = bl;
                tick();
                check("rnd_disp", displays, model_disp(v, bl));
                check("rnd_dbg", debug, v);
                enable = 0;
                tick();
            end
            check("rnd_empty", kb_empty, kbq.size() == 0);
            check("rnd_full", kb_full, kbq.size() == DEPTH);
            check("rnd_ovf", kb_ovf, ovf_m);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/io_port_controller.md
Name: io_port_controller

Overview:
Parametrised, single-clock successor to the processor's I/O block. Serves three CPU I/O operations:
- N-digit hex seven-segment output, with optional leading-zero blanking.
- Switch input with a Confirm press/release handshake that stalls the CPU via Interrupt.
- Buffered PS/2 keyboard input through a byte FIFO, with overflow tracking.
Sits between the CPU's I/O instruction decode and the board peripherals.

Parameters:
DATA_WIDTH, 32, width of CPU data in/out.
NUM_DIGITS, 8, number of seven-segment digits.
SW_WIDTH, 18, switch input width; sign-extended to DATA_WIDTH; must be at most DATA_WIDTH.
KB_DEPTH, 8, keyboard FIFO depth; power of two, at least 2.
SEG_ACTIVE_LOW, 1, 1 means a segment is lit when its bit is 0.

Ports:
Clock  in  1  system clock; all logic on the rising edge.
Reset  in  1  synchronous, active-high.
Enable  in  1  I/O instruction active.
IO  in  2  operation: 0 = 7-seg write, 1 = switch read, 2 = keyboard read, 3 = reserved/no-op.
Data_Out  in  DATA_WIDTH  value to display.
Blank_Leading  in  1  enable leading-zero blanking.
Raw_Input  in  SW_WIDTH  switch bank, signed.
Confirm  in  1  user confirm button, already debounced.
Kb_Byte  in  8  keyboard scan byte.
Kb_Valid  in  1  one-cycle strobe: Kb_Byte is valid.
Data_In  out  DATA_WIDTH  value returned to the CPU.
Data_In_Valid  out  1  one-cycle pulse: Data_In updated.
Interrupt  out  1  CPU stall request.
Kb_Empty  out  1  FIFO empty.
Kb_Full  out  1  FIFO full.
Kb_Overflow  out  1  sticky flag: a byte was dropped.
Debug_7Seg  out  DATA_WIDTH  current display register.
Displays  out  7*NUM_DIGITS  segment patterns; digit k occupies [7k+6:7k], bit order gfedcba.

Behaviour:
- Op = Enable & IO. A new op is accepted only in state IDLE.
- FSM states: IDLE, SW_PRESS, SW_RELEASE, KB_WAIT, DONE.
- Reset: FSM to IDLE; Data_In=0; Data_In_Valid=0; Interrupt=0; FIFO emptied; Kb_Overflow=0; display register=0.
- Reset takes priority over every other event, including mid-handshake.
- After reset, every digit shows "0": 7'b100_0000 when SEG_ACTIVE_LOW=1.
- IO=0 in IDLE:
  - Latch Data_Out into the display register; Displays update on the next edge (1-cycle latency).
  - Then go to DONE.
- Display encoding:
  - Digit k shows nibble k of the register; nibbles beyond DATA_WIDTH read as 0.
  - Register bits above 4*NUM_DIGITS are ignored by the display.
  - Standard hex glyphs 0-F, same table as the existing display.
  - Blank_Leading=1: digits above the most-significant nonzero nibble are all-off. Digit 0 is never blanked.
- IO=1 in IDLE:
  - Go to SW_PRESS; Interrupt=1 from the next cycle.
  - SW_PRESS & Confirm=1: Data_In = sign-extended Raw_Input; go to SW_RELEASE.
  - SW_RELEASE & Confirm=0: Interrupt=0; Data_In_Valid=1 for one cycle; go to DONE.
  - Confirm already high on entry is treated as a press.
  - Raw_Input changes after the press are not captured.
- IO=2 in IDLE:
  - FIFO not empty: Data_In = {0, head byte}; pop; Data_In_Valid pulse; go to DONE. Latency 1 cycle.
  - FIFO empty: Interrupt=1; go to KB_WAIT.
  - KB_WAIT: the byte is pushed into the FIFO; the next cycle sees non-empty, pops it, asserts Data_In_Valid, clears Interrupt, and goes to DONE.
  - Every keyboard read op clears Kb_Overflow on the cycle it completes.
- IO=3: no effect; go to DONE.
- DONE: hold until Op drops (Enable=0), then go to IDLE. A held Enable never retriggers an op.
- FIFO:
  - Kb_Valid pushes at any time, in any state.
  - Push while full and no pop in the same cycle: byte dropped; Kb_Overflow=1.
  - Push and pop in the same cycle while full: both happen; no overflow.
  - Pointers wrap modulo KB_DEPTH.
  - Occupancy counter ranges 0..KB_DEPTH.
  - Kb_Empty and Kb_Full are registered-state derived, with no combinational path from Kb_Valid.
- Data_In holds its value between updates.

Test Plan:
- Reset -> Displays all 7'b100_0000; Data_In=0; Interrupt=0; Kb_Empty=1.
- IO=0, Data_Out=32'h0000_00A5, Blank_Leading=1 -> digit0=A5 low nibble glyph (5 = 7'b001_0010), digit1=A, digits 2-7 = 7'b111_1111; Debug_7Seg=32'hA5.
- IO=1, Raw_Input=18'h3FFFF -> Interrupt high; Confirm pulse 3 cycles -> Data_In=32'hFFFF_FFFF and one Data_In_Valid pulse on release; Enable held 10 cycles -> no second pulse.
- Push 0x1C, 0x32; two IO=2 ops (Enable dropped between them) -> Data_In=0x1C, then 0x32; Kb_Empty=1 after.
- IO=2 with FIFO empty -> Interrupt held; Kb_Valid with 0x5A -> Data_In=0x5A and Interrupt low within 2 cycles.
- Fill KB_DEPTH bytes, push 0xFF -> Kb_Full=1, Kb_Overflow=1, byte dropped; push+pop in the same cycle while full -> no drop. Reset asserted during SW_PRESS -> IDLE, Interrupt=0 next edge.
